// File: rtl/adc_result_fifo.sv
// Result FIFO behind the SAR ADC controller: captures LoadReg-strobed samples, drains over valid/ready,
// counts drops when full. Define ADC_AVG_EN to push one 4-sample average instead of every raw sample.
module adc_result_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          LoadReg,
    input  logic [DW-1:0] B,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    input  logic          ovf_clr
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic [DW-1:0] w_push_data;
    logic          w_push;
    logic          w_drop;

`ifdef ADC_AVG_EN
    logic [9:0] r_acc;
    logic [1:0] r_phase;
    logic [9:0] w_sum;

    assign w_sum       = r_acc + 10'(B);
    assign w_push_req  = LoadReg & (r_phase == 2'd3);
    assign w_push_data = DW'(w_sum >> 2);

    // Accumulation advances on every strobe, whether or not the averaged push is later dropped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (LoadReg) begin
            if (r_phase == 2'd3) begin
                r_acc   <= '0;
                r_phase <= '0;
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + 2'd1;
            end
        end
    end
`else
    assign w_push_req  = LoadReg;
    assign w_push_data = B;
`endif

    assign w_full  = (r_level == DEPTH_L);
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr is counted after the clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_overflow <= w_drop;
            r_drop_cnt <= {7'd0, w_drop};
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = ~w_empty;
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
